// File: rtl/router_pkt_reader_pkg.sv
// Shared router definitions: header field layout, reader FSM states and defaults.
// Imported by the packet reader, its parity accumulator and the stream interface.
package router_pkt_reader_pkg;

  localparam int DATA_W      = 8;
  localparam int LEN_MSB     = 7;
  localparam int LEN_LSB     = 2;
  localparam int ADDR_W      = 2;
  localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
  localparam int LEFT_W      = LEN_W + 1;
  localparam int DEF_TIMEOUT = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_pkt_reader_if.sv
// FIFO read side plus payload push stream of one router output port.
// master = packet reader, slave = FIFO owner / port sink.
interface router_pkt_reader_if;
  import router_pkt_reader_pkg::*;

  logic              vld_out;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic              sink_ready;
  logic              pkt_valid;
  logic [DATA_W-1:0] pkt_data;
  logic              pkt_sop;
  logic              pkt_eop;

  modport master (
    input  vld_out,
    input  data_in,
    input  sink_ready,
    output read_enb,
    output pkt_valid,
    output pkt_data,
    output pkt_sop,
    output pkt_eop
  );

  modport slave (
    output vld_out,
    output data_in,
    output sink_ready,
    input  read_enb,
    input  pkt_valid,
    input  pkt_data,
    input  pkt_sop,
    input  pkt_eop
  );

endinterface

// File: rtl/router_pkt_parity.sv
// Running XOR accumulator shared by the router's receive checker and transmit generator.
// Priority: clr > load > acc_en. match compares din against the running value.
module router_pkt_parity
  import router_pkt_reader_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              load,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] din,
  output logic              match
);

  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = din;
    end else if (acc_en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match = (din == acc_q);

endmodule

// File: rtl/router_pkt_reader.sv
// Destination-side packet reader: drains one router output FIFO, parses header /
// payload / parity, streams payload with SOP/EOP, and keeps packet/error counters.
//
// state | meaning
// IDLE  | waiting for a header byte; issues the header read
// HDR   | header on data_in: capture length/address, load parity
// BODY  | reading payload and the trailing parity byte, starvation watch
// DONE  | one-cycle pkt_done with flags valid; counters update
module router_pkt_reader
  import router_pkt_reader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MY_ADDR = 2'd0,
  parameter int                TIMEOUT = DEF_TIMEOUT,
  parameter int                CNT_W   = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                soft_reset,
  router_pkt_reader_if.master bus,
  output logic                pkt_done,
  output logic                parity_err,
  output logic                addr_err,
  output logic                len_err,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [7:0]          err_cnt
);

  localparam int              STV_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [STV_W-1:0] STV_LOAD = STV_W'(TIMEOUT - 1);

  rd_state_e          state_q, state_d;
  logic               rd_q, rd_d;
  logic [LEFT_W-1:0]  req_left_q, req_left_d;
  logic [LEFT_W-1:0]  rx_left_q, rx_left_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               first_q, first_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic [DATA_W-1:0]  pkt_data_q, pkt_data_d;
  logic               pkt_sop_q, pkt_sop_d;
  logic               pkt_eop_q, pkt_eop_d;
  logic               pkt_done_q, pkt_done_d;
  logic               parity_err_q, parity_err_d;
  logic               addr_err_q, addr_err_d;
  logic               len_err_q, len_err_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               read_enb;
  logic               par_load;
  logic               par_acc;
  logic               par_match;
  logic [LEFT_W-1:0]  len_p1;
  logic               any_err;

  // Reads never run past the parity byte, so the next packet stays in the FIFO.
  always_comb begin
    read_enb = 1'b0;
    if (!soft_reset) begin
      case (state_q)
        IDLE:    read_enb = bus.vld_out & bus.sink_ready;
        BODY:    read_enb = bus.vld_out & bus.sink_ready & (req_left_q != '0);
        default: read_enb = 1'b0;
      endcase
    end
  end

  assign par_load = (state_q == HDR);
  assign par_acc  = (state_q == BODY) && rd_q && (rx_left_q > LEFT_W'(1));
  assign len_p1   = {1'b0, hdr_len(bus.data_in)} + LEFT_W'(1);
  assign any_err  = parity_err_q | addr_err_q | len_err_q | timeout_err_q;

  router_pkt_parity u_parity (
    .clock  (clock),
    .resetn (resetn),
    .clr    (soft_reset),
    .load   (par_load),
    .acc_en (par_acc),
    .din    (bus.data_in),
    .match  (par_match)
  );

  always_comb begin
    state_d       = state_q;
    rd_d          = read_enb;
    req_left_d    = req_left_q;
    rx_left_d     = rx_left_q;
    starve_d      = starve_q;
    first_d       = first_q;
    pkt_valid_d   = 1'b0;
    pkt_data_d    = pkt_data_q;
    pkt_sop_d     = 1'b0;
    pkt_eop_d     = 1'b0;
    pkt_done_d    = 1'b0;
    parity_err_d  = parity_err_q;
    addr_err_d    = addr_err_q;
    len_err_d     = len_err_q;
    timeout_err_d = timeout_err_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_cnt_d     = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (read_enb) begin
          state_d = HDR;
        end
      end

      HDR: begin
        req_left_d    = len_p1;
        rx_left_d     = len_p1;
        starve_d      = STV_LOAD;
        first_d       = 1'b1;
        len_err_d     = (hdr_len(bus.data_in) == '0);
        addr_err_d    = (hdr_addr(bus.data_in) != MY_ADDR);
        parity_err_d  = 1'b0;
        timeout_err_d = 1'b0;
        state_d       = BODY;
      end

      BODY: begin
        if (read_enb) begin
          req_left_d = req_left_q - LEFT_W'(1);
        end
        if (rd_q) begin
          rx_left_d = rx_left_q - LEFT_W'(1);
          starve_d  = STV_LOAD;
          if (rx_left_q > LEFT_W'(1)) begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = bus.data_in;
            pkt_sop_d   = first_q;
            pkt_eop_d   = (rx_left_q == LEFT_W'(2));
            first_d     = 1'b0;
          end else begin
            parity_err_d = !par_match;
            pkt_done_d   = 1'b1;
            state_d      = DONE;
          end
        end else if (bus.vld_out) begin
          starve_d = STV_LOAD;
        end else if (starve_q <= STV_W'(1)) begin
          // The DONE cycle itself is the last starved cycle of the window.
          timeout_err_d = 1'b1;
          pkt_done_d    = 1'b1;
          state_d       = DONE;
        end else begin
          starve_d = starve_q - STV_W'(1);
        end
      end

      DONE: begin
        if (any_err) begin
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (soft_reset) begin
      state_d       = IDLE;
      rd_d          = 1'b0;
      req_left_d    = '0;
      rx_left_d     = '0;
      starve_d      = STV_LOAD;
      first_d       = 1'b0;
      pkt_valid_d   = 1'b0;
      pkt_sop_d     = 1'b0;
      pkt_eop_d     = 1'b0;
      pkt_done_d    = 1'b0;
      parity_err_d  = 1'b0;
      addr_err_d    = 1'b0;
      len_err_d     = 1'b0;
      timeout_err_d = 1'b0;
      pkt_cnt_d     = pkt_cnt_q;
      err_cnt_d     = err_cnt_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      rd_q          <= 1'b0;
      req_left_q    <= '0;
      rx_left_q     <= '0;
      starve_q      <= STV_LOAD;
      first_q       <= 1'b0;
      pkt_valid_q   <= 1'b0;
      pkt_data_q    <= '0;
      pkt_sop_q     <= 1'b0;
      pkt_eop_q     <= 1'b0;
      pkt_done_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      addr_err_q    <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      pkt_cnt_q     <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      req_left_q    <= req_left_d;
      rx_left_q     <= rx_left_d;
      starve_q      <= starve_d;
      first_q       <= first_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_data_q    <= pkt_data_d;
      pkt_sop_q     <= pkt_sop_d;
      pkt_eop_q     <= pkt_eop_d;
      pkt_done_q    <= pkt_done_d;
      parity_err_q  <= parity_err_d;
      addr_err_q    <= addr_err_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.read_enb  = read_enb;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_data  = pkt_data_q;
  assign bus.pkt_sop   = pkt_sop_q;
  assign bus.pkt_eop   = pkt_eop_q;
  assign pkt_done      = pkt_done_q;
  assign parity_err    = parity_err_q;
  assign addr_err      = addr_err_q;
  assign len_err       = len_err_q;
  assign timeout_err   = timeout_err_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule
